// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - slot encodings, cache states and ADDR slot packing shared by the ring cache
package ring_pkg;

  typedef enum logic [1:0] {
    SLOT_NULL  = 2'd0,
    SLOT_TOKEN = 2'd1,
    SLOT_ADDR  = 2'd2,
    SLOT_DATA  = 2'd3
  } slot_kind_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_RADDR,
    S_FILL,
    S_RDONE,
    S_WADDR,
    S_WDATA,
    S_WDONE
  } cache_state_e;

  // ADDR payload: line address in the low bits, then the write flag, then the cache type.
  function automatic logic [31:0] addr_slot_word(input logic [29:0] line_addr, input logic write,
                                                 input logic ctype, input int nbwords);
    logic [31:0] w;
    w = {2'b00, line_addr};
    w[30-nbwords] = write;
    w[31-nbwords] = ctype;
    return w;
  endfunction

endpackage

// File: rtl/ring_cache_if.sv
// rtl/ring_cache_if.sv - CPU-side request/response port of the ring cache
interface ring_cache_if;
  logic        rd;
  logic        force_miss;
  logic        wr;
  logic [31:2] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdy;

  modport master (output rd, force_miss, wr, addr, wdata, input rdata, rdy);
  modport slave  (input rd, force_miss, wr, addr, wdata, output rdata, rdy);
endinterface

// File: rtl/ring_cache_way.sv
// rtl/ring_cache_way.sv - one way of the cache: data array, tag array and tag compare
module cache_way #(
  parameter int NBLINES = 7,
  parameter int NBWORDS = 3
) (
  input  logic                              clk,
  input  logic [NBLINES-1:0]                index,
  input  logic [NBWORDS-1:0]                offset,
  input  logic [29-NBLINES-NBWORDS:0]       tag,
  input  logic                              data_we,
  input  logic [NBWORDS-1:0]                data_word,
  input  logic [31:0]                       data_in,
  input  logic                              tag_we,
  output logic [31:0]                       word,
  output logic                              match
);

  logic [31:0]                 data_mem [2**(NBLINES+NBWORDS)];
  logic [29-NBLINES-NBWORDS:0] tag_mem  [2**NBLINES];

  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[{index, data_word}] <= data_in;
    end
    if (tag_we) begin
      tag_mem[index] <= tag;
    end
  end

  assign word  = data_mem[{index, offset}];
  assign match = (tag_mem[index] == tag);

endmodule

// File: rtl/ring_cache.sv
// rtl/ring_cache.sv - two-way write-through, no-write-allocate cache between a CPU port and the ring
module ring_cache
  import ring_pkg::*;
#(
  parameter int TSIZE   = 4,
  parameter int NBLINES = 7,
  parameter int NBWORDS = 3,
  parameter int CTYPE   = 0
) (
  input  logic               clk,
  input  logic               reset,
  ring_cache_if.slave        cpu,
  output logic               ring_req,
  input  logic               ring_ack,
  output logic               drive_ring,
  output logic [TSIZE-1:0]   slot_type,
  output logic [31:0]        slot_data,
  input  logic               mc_ack_in,
  output logic               mc_ack_out,
  input  logic [NBWORDS-1:0] mc_count,
  input  logic [31:0]        mc_data
);

  localparam int NSETS = 2**NBLINES;

  cache_state_e state, state_next;

  logic [NBLINES-1:0]          index;
  logic [NBWORDS-1:0]          offset;
  logic [29-NBLINES-NBWORDS:0] tag;
  logic [29-NBWORDS:0]         line_addr;

  logic [NSETS-1:0] valid [2];
  logic [NSETS-1:0] lru;
  logic             victim;
  logic             victim_sel;

  logic [31:0]        way_word [2];
  logic [1:0]         way_match;
  logic [1:0]         hit_way;
  logic               hit;
  logic               hit_sel;
  logic [1:0]         data_we;
  logic [1:0]         tag_we;
  logic [NBWORDS-1:0] data_word;
  logic [31:0]        data_in;
  logic               fill_last;
  logic               done;

  assign offset    = cpu.addr[NBWORDS+1:2];
  assign index     = cpu.addr[NBWORDS+NBLINES+1:NBWORDS+2];
  assign tag       = cpu.addr[31:NBWORDS+NBLINES+2];
  assign line_addr = cpu.addr[31:NBWORDS+2];

  assign hit_way   = {valid[1][index] & way_match[1], valid[0][index] & way_match[0]};
  assign hit       = |hit_way;
  assign hit_sel   = hit_way[1];
  assign fill_last = (state == S_FILL) && mc_ack_in && (&mc_count);

  // A forced miss refills the line in the way already holding it, so a tag never lives in both ways.
  always_comb begin
    victim_sel = lru[index];
    if (hit) begin
      victim_sel = hit_sel;
    end else if (!valid[0][index]) begin
      victim_sel = 1'b0;
    end else if (!valid[1][index]) begin
      victim_sel = 1'b1;
    end
  end

  cache_way #(.NBLINES(NBLINES), .NBWORDS(NBWORDS)) way0 (
    .clk(clk), .index(index), .offset(offset), .tag(tag),
    .data_we(data_we[0]), .data_word(data_word), .data_in(data_in), .tag_we(tag_we[0]),
    .word(way_word[0]), .match(way_match[0])
  );

  cache_way #(.NBLINES(NBLINES), .NBWORDS(NBWORDS)) way1 (
    .clk(clk), .index(index), .offset(offset), .tag(tag),
    .data_we(data_we[1]), .data_word(data_word), .data_in(data_in), .tag_we(tag_we[1]),
    .word(way_word[1]), .match(way_match[1])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (cpu.wr) begin
          state_next = S_WADDR;
        end else if (cpu.rd) begin
          state_next = (hit && !cpu.force_miss) ? S_HIT : S_RADDR;
        end
      end
      S_HIT:   state_next = S_IDLE;
      S_RADDR: if (ring_ack) state_next = S_FILL;
      S_FILL:  if (fill_last) state_next = S_RDONE;
      S_RDONE: state_next = S_IDLE;
      S_WADDR: if (ring_ack) state_next = S_WDATA;
      S_WDATA: if (ring_ack) state_next = S_WDONE;
      S_WDONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ring_req   = (state == S_RADDR) || (state == S_WADDR) || (state == S_WDATA);
    drive_ring = ring_req && ring_ack;
    slot_type  = TSIZE'(SLOT_NULL);
    slot_data  = '0;
    if (drive_ring) begin
      if (state == S_WDATA) begin
        slot_type = TSIZE'(SLOT_DATA);
        slot_data = cpu.wdata;
      end else begin
        slot_type = TSIZE'(SLOT_ADDR);
        slot_data = addr_slot_word(30'(line_addr), state == S_WADDR, CTYPE != 0, NBWORDS);
      end
    end
    done       = (state == S_HIT) || (state == S_RDONE) || (state == S_WDONE);
    mc_ack_out = (state == S_FILL) ? 1'b0 : mc_ack_in;
    data_word  = offset;
    data_in    = cpu.wdata;
    data_we    = 2'b00;
    tag_we     = 2'b00;
    if (state == S_FILL) begin
      data_word = mc_count;
      data_in   = mc_data;
      if (mc_ack_in) data_we[victim] = 1'b1;
      if (fill_last) tag_we[victim] = 1'b1;
    end else if (state == S_WDATA && ring_ack) begin
      data_we = hit_way;
    end
  end

  assign cpu.rdy   = done;
  assign cpu.rdata = hit_sel ? way_word[1] : way_word[0];

  // The refill target is invalidated up front so an aborted fill never leaves a half-written valid line.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= '{default: '0};
      lru    <= '0;
      victim <= 1'b0;
    end else begin
      if (state == S_IDLE && !cpu.wr && cpu.rd) begin
        if (hit && !cpu.force_miss) begin
          lru[index] <= ~hit_sel;
        end else begin
          victim                   <= victim_sel;
          valid[victim_sel][index] <= 1'b0;
        end
      end
      if (fill_last) begin
        valid[victim][index] <= 1'b1;
        lru[index]           <= ~victim;
      end
    end
  end

endmodule

// File: tb/tb_ring_cache.sv
// tb/tb_ring_cache.sv - directed bench for ring_cache against a line-level LRU cache model
module tb_ring_cache;
  import ring_pkg::*;

  localparam int NBW   = 3;
  localparam int NBL   = 7;
  localparam int NSETS = 2**NBL;
  localparam int CT    = 0;

  typedef struct { logic [3:0] kind; logic [31:0] data; } slot_t;
  typedef struct { bit is_read; logic [31:0] data; } resp_t;

  logic clk, reset, ring_ack, mc_ack_in;
  logic ring_req, drive_ring, mc_ack_out;
  logic [3:0]  slot_type;
  logic [31:0] slot_data, mc_data;
  logic [2:0]  mc_count;

  ring_cache_if cpu_if ();

  ring_cache #(.TSIZE(4), .NBLINES(NBL), .NBWORDS(NBW), .CTYPE(CT)) dut (
    .clk(clk), .reset(reset), .cpu(cpu_if),
    .ring_req(ring_req), .ring_ack(ring_ack), .drive_ring(drive_ring),
    .slot_type(slot_type), .slot_data(slot_data),
    .mc_ack_in(mc_ack_in), .mc_ack_out(mc_ack_out), .mc_count(mc_count), .mc_data(mc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit in_fill = 0;
  logic [31:0] last_addr_slot = '0;
  logic [31:0] last_rdata = '0;

  slot_t exp_slots[$];
  resp_t exp_resp[$];

  // Model: per set, resident line addresses ordered least- to most-recently used; word contents by word address.
  int unsigned set_lines [NSETS][$];
  logic [31:0] mem [int unsigned];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int find_line(input int unsigned line);
    int unsigned s = line % NSETS;
    for (int i = 0; i < set_lines[s].size(); i++) if (set_lines[s][i] == line) return i;
    return -1;
  endfunction

  function automatic void make_mru(input int unsigned line);
    int unsigned s = line % NSETS;
    int p = find_line(line);
    if (p >= 0) set_lines[s].delete(p);
    else if (set_lines[s].size() == 2) void'(set_lines[s].pop_front());
    set_lines[s].push_back(line);
  endfunction

  function automatic logic [31:0] model_addr_slot(input int unsigned line, input int w);
    return (32'(CT) << (31 - NBW)) | (32'(w) << (30 - NBW)) | 32'(line);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (drive_ring) begin
        if (exp_slots.size() == 0) begin
          check("unexpected_slot", 32'(drive_ring), 32'd0);
        end else begin
          slot_t s;
          s = exp_slots.pop_front();
          check("slot_type", 32'(slot_type), 32'(s.kind));
          check("slot_data", slot_data, s.data);
        end
        if (slot_type == 4'(SLOT_ADDR)) last_addr_slot = slot_data;
      end else begin
        check("idle_slot_type", 32'(slot_type), 32'(SLOT_NULL));
        check("idle_slot_data", slot_data, 32'd0);
      end
      check("drive_without_ack", 32'(drive_ring && !ring_ack), 32'd0);
      check("mc_ack_out", 32'(mc_ack_out), 32'(mc_ack_in && !in_fill));
      if (cpu_if.rdy) begin
        if (exp_resp.size() == 0) begin
          check("unexpected_rdy", 32'(cpu_if.rdy), 32'd0);
        end else begin
          resp_t r;
          r = exp_resp.pop_front();
          if (r.is_read) check("rdata", cpu_if.rdata, r.data);
          last_rdata = cpu_if.rdata;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:2] a, input bit force_it, input int hold, input logic [31:0] base);
    int unsigned wa = 32'(a);
    int unsigned line = wa >> NBW;
    bit hit = (find_line(line) >= 0) && !force_it;
    cpu_if.rd = 1'b1;
    cpu_if.force_miss = force_it;
    cpu_if.addr = a;
    if (hit) begin
      make_mru(line);
      exp_resp.push_back('{1'b1, mem[wa]});
      tick();
      @(negedge clk) check("hit_rdy_latency", 32'(cpu_if.rdy), 32'd1);
    end else begin
      exp_slots.push_back('{4'(SLOT_ADDR), model_addr_slot(line, 0)});
      tick();
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("wait_ring_req", 32'(ring_req), 32'd1);
        check("wait_drive", 32'(drive_ring), 32'd0);
        check("wait_rdy", 32'(cpu_if.rdy), 32'd0);
        tick();
      end
      ring_ack = 1'b1;
      @(negedge clk) check("ack_ring_req", 32'(ring_req), 32'd1);
      tick();
      ring_ack = 1'b0;
      in_fill = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (i == 4) begin
          mc_ack_in = 1'b0;
          @(negedge clk) check("fill_gap_rdy", 32'(cpu_if.rdy), 32'd0);
          tick();
        end
        mc_ack_in = 1'b1;
        mc_count = 3'(i);
        mc_data = base + 32'(i);
        tick();
      end
      mc_ack_in = 1'b0;
      in_fill = 1'b0;
      make_mru(line);
      for (int i = 0; i < 8; i++) mem[(line << NBW) + i] = base + 32'(i);
      exp_resp.push_back('{1'b1, mem[wa]});
      @(negedge clk) check("fill_rdy", 32'(cpu_if.rdy), 32'd1);
    end
    tick();
    cpu_if.rd = 1'b0;
    cpu_if.force_miss = 1'b0;
  endtask

  task automatic do_write(input logic [31:2] a, input logic [31:0] d, input bit also_rd);
    int unsigned wa = 32'(a);
    int unsigned line = wa >> NBW;
    cpu_if.wr = 1'b1;
    cpu_if.rd = also_rd;
    cpu_if.addr = a;
    cpu_if.wdata = d;
    exp_slots.push_back('{4'(SLOT_ADDR), model_addr_slot(line, 1)});
    exp_slots.push_back('{4'(SLOT_DATA), d});
    exp_resp.push_back('{1'b0, 32'd0});
    tick();
    ring_ack = 1'b1;
    tick();
    tick();
    ring_ack = 1'b0;
    @(negedge clk) check("write_rdy", 32'(cpu_if.rdy), 32'd1);
    tick();
    cpu_if.wr = 1'b0;
    cpu_if.rd = 1'b0;
    if (find_line(line) >= 0) mem[wa] = d;
  endtask

  initial begin
    reset = 1'b1;
    ring_ack = 1'b0;
    mc_ack_in = 1'b0;
    mc_count = '0;
    mc_data = '0;
    cpu_if.rd = 1'b0;
    cpu_if.wr = 1'b0;
    cpu_if.force_miss = 1'b0;
    cpu_if.addr = '0;
    cpu_if.wdata = '0;
    tick();
    tick();
    @(negedge clk);
    check("reset_rdy", 32'(cpu_if.rdy), 32'd0);
    check("reset_ring_req", 32'(ring_req), 32'd0);
    check("reset_drive_ring", 32'(drive_ring), 32'd0);
    check("reset_slot_type", 32'(slot_type), 32'd0);
    check("reset_slot_data", slot_data, 32'd0);
    tick();
    reset = 1'b0;

    do_read(30'h100, 0, 0, 32'hA0);
    check("cold_miss_addr_slot", last_addr_slot, 32'h0000_0020);
    check("cold_miss_rdata", last_rdata, 32'h0000_00A0);
    do_read(30'h100, 0, 0, 32'h0);
    check("repeat_hit_rdata", last_rdata, 32'h0000_00A0);
    do_write(30'h101, 32'hDEAD_BEEF, 0);
    check("write_addr_slot", last_addr_slot, 32'h0800_0020);
    do_read(30'h101, 0, 0, 32'h0);
    check("write_hit_rdata", last_rdata, 32'hDEAD_BEEF);

    do_write(30'h3000, 32'h1234_5678, 1);
    do_read(30'h3000, 0, 0, 32'h300);

    do_read(30'h500, 0, 0, 32'hB0);
    do_read(30'h900, 0, 0, 32'hC0);
    do_read(30'h100, 0, 0, 32'hD0);
    check("evicted_refill_slot", last_addr_slot, 32'h0000_0020);
    check("evicted_refill_rdata", last_rdata, 32'h0000_00D0);

    do_read(30'h505, 0, 5, 32'hE0);

    mc_ack_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mc_count = 3'(i);
      mc_data = 32'h5A5A_0000 + 32'(i);
      tick();
    end
    mc_ack_in = 1'b0;
    do_read(30'h102, 0, 0, 32'h0);
    check("idle_return_untouched", last_rdata, 32'h0000_00D2);

    do_read(30'h100, 1, 0, 32'hF0);
    check("force_miss_rdata", last_rdata, 32'h0000_00F0);
    do_read(30'h103, 0, 0, 32'h0);
    check("force_refilled_word", last_rdata, 32'h0000_00F3);

    cpu_if.rd = 1'b1;
    cpu_if.addr = 30'h900;
    exp_slots.push_back('{4'(SLOT_ADDR), model_addr_slot(32'h900 >> NBW, 0)});
    tick();
    ring_ack = 1'b1;
    tick();
    ring_ack = 1'b0;
    in_fill = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mc_ack_in = 1'b1;
      mc_count = 3'(i);
      mc_data = 32'h7700 + 32'(i);
      tick();
    end
    reset = 1'b1;
    cpu_if.rd = 1'b0;
    mc_ack_in = 1'b0;
    tick();
    reset = 1'b0;
    in_fill = 1'b0;
    mc_ack_in = 1'b1;
    mc_count = 3'd2;
    @(negedge clk);
    check("abort_ring_req", 32'(ring_req), 32'd0);
    check("abort_rdy", 32'(cpu_if.rdy), 32'd0);
    tick();
    mc_ack_in = 1'b0;
    for (int s = 0; s < NSETS; s++) set_lines[s].delete();
    do_read(30'h100, 0, 0, 32'h55);
    check("post_reset_rdata", last_rdata, 32'h0000_0055);

    tick();
    check("slots_drained", 32'(exp_slots.size()), 32'd0);
    check("resps_drained", 32'(exp_resp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
